adc_feature_sequencer: RTL and testbench

Sequential front-end that drives one shared, multiplexed sensor ADC across the classifier's seven input features. It quantizes each conversion to the classifier's 4-bit feature width and assembles the 28-bit feature vector. It presents that vector atomically to the combinational printed-MLP classifier and registers the classifier's 2-bit class result. Channels whose features carry all-zero first-layer weights are masked out at build time and are never converted, which saves ADC energy.

---
 rtl/adc_feature_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_adc_feature_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_feature_sequencer.sv
// Sequences a shared multiplexed ADC across the classifier features, quantizes each
// conversion and hands the assembled vector to the classifier atomically.
module adc_feature_sequencer #(
    parameter int unsigned          N_FEAT    = 7,
    parameter int unsigned          FEAT_W    = 4,
    parameter int unsigned          ADC_W     = 8,
    parameter int unsigned          SETTLE    = 2,
    parameter int unsigned          TIMEOUT   = 64,
    parameter int unsigned          ROUND     = 1,
    parameter logic [N_FEAT-1:0]    SKIP_MASK = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic [2:0]                 adc_sel,
    output logic                       adc_soc,
    input  logic                       adc_eoc,
    input  logic [ADC_W-1:0]           adc_data,
    output logic [N_FEAT*FEAT_W-1:0]   feat_vec,
    output logic                       feat_valid,
    input  logic [1:0]                 class_in,
    output logic [1:0]                 class_out,
    output logic                       class_valid,
    output logic                       err
);

    localparam int unsigned CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CONVERT,
        S_DONE,
        S_CAPTURE
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [2:0]                 r_chan;
    logic [2:0]                 w_chan_nxt;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic [N_FEAT*FEAT_W-1:0]   r_shadow;
    logic [N_FEAT*FEAT_W-1:0]   w_shadow_nxt;
    logic [N_FEAT*FEAT_W-1:0]   r_feat_vec;
    logic [1:0]                 r_class;
    logic                       r_err;
    logic                       w_err_nxt;

    logic [2:0]                 w_first_chan;
    logic                       w_first_found;
    logic [2:0]                 w_next_chan;
    logic                       w_next_found;
    logic                       w_eoc_ok;
    logic                       w_tmo;

    logic [FEAT_W-1:0]          w_trunc;
    logic [FEAT_W-1:0]          w_quant;
    logic                       w_unused_adc;

    assign w_trunc      = adc_data[ADC_W-1 -: FEAT_W];
    assign w_unused_adc = ^adc_data;

    generate
        if (ROUND != 0 && ADC_W > FEAT_W) begin : g_round
            logic [FEAT_W:0] w_sum;
            assign w_sum   = {1'b0, w_trunc} + {{FEAT_W{1'b0}}, adc_data[ADC_W-FEAT_W-1]};
            assign w_quant = w_sum[FEAT_W] ? '1 : w_sum[FEAT_W-1:0];
        end else begin : g_trunc
            assign w_quant = w_trunc;
        end
    endgenerate

    // Channel walk order is fixed at build time by SKIP_MASK; masked channels never appear.
    always_comb begin
        w_first_found = 1'b0;
        w_first_chan  = '0;
        w_next_found  = 1'b0;
        w_next_chan   = '0;
        for (int unsigned i = 0; i < N_FEAT; i++) begin
            if (!SKIP_MASK[i] && !w_first_found) begin
                w_first_found = 1'b1;
                w_first_chan  = 3'(i);
            end
            if (!SKIP_MASK[i] && !w_next_found && (3'(i) > r_chan)) begin
                w_next_found = 1'b1;
                w_next_chan  = 3'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_chan_nxt   = r_chan;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_err_nxt    = r_err;
        w_eoc_ok     = 1'b0;
        w_tmo        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_shadow_nxt = '0;
                    w_err_nxt    = 1'b0;
                    w_cnt_nxt    = '0;
                    if (w_first_found) begin
                        w_state_nxt = S_SELECT;
                        w_chan_nxt  = w_first_chan;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_SELECT: begin
                if (r_cnt == CNT_W'(SETTLE - 1)) begin
                    w_state_nxt = S_CONVERT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_CONVERT: begin
                // eoc in the soc cycle is ignored; eoc in the timeout cycle still wins.
                w_eoc_ok = adc_eoc && (r_cnt != '0);
                w_tmo    = !adc_eoc && (r_cnt == CNT_W'(TIMEOUT));
                if (w_eoc_ok || w_tmo) begin
                    for (int unsigned i = 0; i < N_FEAT; i++) begin
                        if (r_chan == 3'(i)) begin
                            w_shadow_nxt[i*FEAT_W +: FEAT_W] = w_eoc_ok ? w_quant : '0;
                        end
                    end
                    if (w_tmo) begin
                        w_err_nxt = 1'b1;
                    end
                    w_cnt_nxt = '0;
                    if (w_next_found) begin
                        w_state_nxt = S_SELECT;
                        w_chan_nxt  = w_next_chan;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE:    w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_chan     <= '0;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_feat_vec <= '0;
            r_class    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_chan   <= w_chan_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_err    <= w_err_nxt;
            // Loading on DONE entry lets feat_vec and feat_valid appear in the same cycle.
            if (w_state_nxt == S_DONE) begin
                r_feat_vec <= w_shadow_nxt;
            end
            if (r_state == S_DONE) begin
                r_class <= class_in;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign adc_sel     = r_chan;
    assign adc_soc     = (r_state == S_CONVERT) && (r_cnt == '0);
    assign feat_vec    = r_feat_vec;
    assign feat_valid  = (r_state == S_DONE);
    assign class_out   = r_class;
    assign class_valid = (r_state == S_CAPTURE);
    assign err         = r_err;

endmodule

// File: tb/tb_adc_feature_sequencer.sv
// Directed bench: three sequencer builds (full, channel-1 masked with truncation, all masked)
// driven by a shared behavioural ADC and a toy classifier.
module tb_adc_feature_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start_s [3];
    logic        busy_s  [3];
    logic [2:0]  sel_s   [3];
    logic        soc_s   [3];
    logic        eoc_s   [3];
    logic [7:0]  data_s  [3];
    logic [27:0] vec_s   [3];
    logic        fval_s  [3];
    logic [1:0]  cin_s   [3];
    logic [1:0]  cout_s  [3];
    logic        cval_s  [3];
    logic        err_s   [3];

    int n_chk  = 0;
    int n_pass = 0;

    int         adc_e      = 3;
    bit         adc_ramp   = 1'b1;
    logic [7:0] adc_fixed  = 8'h00;
    int         dead_ch    = -1;
    int         cnt    [3] = '{0, 0, 0};
    int         ch     [3] = '{0, 0, 0};
    int         soc_cnt[3] = '{0, 0, 0};
    int         fv_cnt [3] = '{0, 0, 0};
    bit         sel1_seen  = 1'b0;

    adc_feature_sequencer dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .busy(busy_s[0]),
        .adc_sel(sel_s[0]), .adc_soc(soc_s[0]), .adc_eoc(eoc_s[0]), .adc_data(data_s[0]),
        .feat_vec(vec_s[0]), .feat_valid(fval_s[0]), .class_in(cin_s[0]),
        .class_out(cout_s[0]), .class_valid(cval_s[0]), .err(err_s[0])
    );

    adc_feature_sequencer #(.SKIP_MASK(7'b0000010), .ROUND(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .busy(busy_s[1]),
        .adc_sel(sel_s[1]), .adc_soc(soc_s[1]), .adc_eoc(eoc_s[1]), .adc_data(data_s[1]),
        .feat_vec(vec_s[1]), .feat_valid(fval_s[1]), .class_in(cin_s[1]),
        .class_out(cout_s[1]), .class_valid(cval_s[1]), .err(err_s[1])
    );

    adc_feature_sequencer #(.SKIP_MASK(7'b1111111)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .busy(busy_s[2]),
        .adc_sel(sel_s[2]), .adc_soc(soc_s[2]), .adc_eoc(eoc_s[2]), .adc_data(data_s[2]),
        .feat_vec(vec_s[2]), .feat_valid(fval_s[2]), .class_in(cin_s[2]),
        .class_out(cout_s[2]), .class_valid(cval_s[2]), .err(err_s[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] classify(input logic [27:0] v);
        return 2'(v[1:0] + v[9:8] + v[25:24]);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // ADC: eoc exactly adc_e cycles after soc; classifier: combinational view of feat_vec.
    initial begin
        for (int d = 0; d < 3; d++) begin
            eoc_s[d] = 1'b0; data_s[d] = 8'h00; cin_s[d] = 2'b00;
        end
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                cin_s[d] = classify(vec_s[d]);
                eoc_s[d] = 1'b0;
                if (!busy_s[d]) begin
                    cnt[d] = 0;
                end else if (soc_s[d]) begin
                    cnt[d] = adc_e;
                    ch[d]  = int'(sel_s[d]);
                    soc_cnt[d]++;
                end else if (cnt[d] > 0) begin
                    cnt[d]--;
                    if (cnt[d] == 0 && ch[d] != dead_ch) begin
                        eoc_s[d]  = 1'b1;
                        data_s[d] = adc_ramp ? 8'(8'h10 * ch[d] + 8'h08) : adc_fixed;
                    end
                end
                if (fval_s[d]) fv_cnt[d]++;
            end
            if (sel_s[1] == 3'd1) sel1_seen = 1'b1;
        end
    end

    // Called at #1 into an IDLE cycle; returns at #1 into the IDLE cycle after CAPTURE.
    task automatic do_frame(input int d, input logic [27:0] ev, input int ecyc,
                            input logic eerr, input string nm);
        int n;
        bit seen;
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        check({nm, " busy/err@1"}, 32'({busy_s[d], err_s[d]}), 32'b10);
        seen = 1'b0;
        for (n = 1; n < 2000; n++) begin
            if (fval_s[d]) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({nm, " feat_cycle"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(ecyc));
        if (seen) begin
            check({nm, " feat_vec"}, 32'(vec_s[d]), 32'(ev));
            @(posedge clk); #1;
            check({nm, " class_valid/feat_valid"}, 32'({cval_s[d], fval_s[d]}), 32'b10);
            check({nm, " class_out"}, 32'(cout_s[d]), 32'(classify(ev)));
            check({nm, " err"}, 32'(err_s[d]), 32'(eerr));
            @(posedge clk); #1;
            check({nm, " idle after"}, 32'({busy_s[d], cval_s[d], err_s[d]}), 32'({2'b00, eerr}));
        end
    endtask

    typedef struct {
        int         dut;
        bit         ramp;
        logic [7:0] data;
        int         e;
        logic [27:0] exp_vec;
        int         exp_cyc;
        int         exp_soc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n;
        int fvb;
        bit seen;

        tbl[0]  = '{0, 1'b1, 8'h00, 3,  28'h7654321, 43,  7};
        tbl[1]  = '{1, 1'b1, 8'h00, 3,  28'h6543200, 37,  6};
        tbl[2]  = '{0, 1'b0, 8'hF8, 3,  28'hFFFFFFF, 43,  7};
        tbl[3]  = '{1, 1'b0, 8'hF8, 3,  28'hFFFFF0F, 37,  6};
        tbl[4]  = '{0, 1'b0, 8'h17, 1,  28'h1111111, 29,  7};
        tbl[5]  = '{1, 1'b0, 8'h17, 1,  28'h1111101, 25,  6};
        tbl[6]  = '{0, 1'b0, 8'h18, 3,  28'h2222222, 43,  7};
        tbl[7]  = '{1, 1'b0, 8'h18, 3,  28'h1111101, 37,  6};
        tbl[8]  = '{0, 1'b0, 8'hFF, 64, 28'hFFFFFFF, 470, 7};
        tbl[9]  = '{0, 1'b0, 8'h07, 2,  28'h0000000, 36,  7};
        tbl[10] = '{2, 1'b1, 8'h00, 3,  28'h0000000, 1,   0};

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) start_s[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset ctrl dut%0d", d),
                  32'({busy_s[d], sel_s[d], soc_s[d], fval_s[d], cout_s[d], cval_s[d], err_s[d]}), 32'd0);
            check($sformatf("reset vec dut%0d", d), 32'(vec_s[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            adc_e     = tbl[i].e;
            adc_ramp  = tbl[i].ramp;
            adc_fixed = tbl[i].data;
            dead_ch   = -1;
            soc_cnt[tbl[i].dut] = 0;
            do_frame(tbl[i].dut, tbl[i].exp_vec, tbl[i].exp_cyc, 1'b0, $sformatf("row%0d", i));
            check($sformatf("row%0d soc_count", i), 32'(soc_cnt[tbl[i].dut]), 32'(tbl[i].exp_soc));
        end
        check("mask sel1 never", 32'(sel1_seen), 32'd0);

        // Channel 3 dead: timeout costs SETTLE+TIMEOUT+1 = 67 cycles.
        adc_e = 3; adc_ramp = 1'b1; dead_ch = 3;
        do_frame(0, 28'h7650321, 1 + 6 * 6 + 67, 1'b1, "timeout");
        dead_ch = -1;
        do_frame(0, 28'h7654321, 43, 1'b0, "after timeout");

        // Reset during channel 4 CONVERT (soc at cycle 1 + 4*6 + 2 = 27).
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        seen = 1'b0;
        for (n = 1; n < 200; n++) begin
            if (soc_s[0] && sel_s[0] == 3'd4) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("ch4 soc cycle", seen ? 32'(n) : 32'hFFFF_FFFF, 32'd27);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset ctrl",
              32'({busy_s[0], sel_s[0], soc_s[0], fval_s[0], cout_s[0], cval_s[0], err_s[0]}), 32'd0);
        check("midreset vec", 32'(vec_s[0]), 32'd0);
        rst_n = 1'b1;
        fvb = fv_cnt[0];
        repeat (60) @(posedge clk);
        #1;
        check("midreset no feat_valid", 32'(fv_cnt[0] - fvb), 32'd0);
        do_frame(0, 28'h7654321, 43, 1'b0, "post reset");

        // Starts while busy (including DONE and CAPTURE) must be dropped.
        fvb = fv_cnt[0];
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        for (n = 1; n <= 80; n++) begin
            start_s[0] = (n == 5 || n == 20 || n == 43 || n == 44);
            @(posedge clk); #1;
        end
        start_s[0] = 1'b0;
        check("busy starts ignored", 32'(fv_cnt[0] - fvb), 32'd1);
        check("idle after ignored", 32'(busy_s[0]), 32'd0);

        // start held: CAPTURE -> one IDLE cycle -> SELECT.
        start_s[0] = 1'b1;
        seen = 1'b0;
        for (n = 1; n < 200; n++) begin
            @(posedge clk); #1;
            if (cval_s[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check("held class_valid cycle", seen ? 32'(n) : 32'hFFFF_FFFF, 32'd44);
        @(posedge clk); #1;
        check("held idle gap busy", 32'(busy_s[0]), 32'd0);
        @(posedge clk); #1;
        check("held select", 32'({busy_s[0], soc_s[0], sel_s[0]}), 32'b10_000);
        seen = 1'b0;
        for (n = 1; n < 200; n++) begin
            if (fval_s[0]) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("held second feat_valid", seen ? 32'(n) : 32'hFFFF_FFFF, 32'd43);
        check("held second vec", 32'(vec_s[0]), 32'h7654321);
        start_s[0] = 1'b0;
        for (n = 0; n < 100 && busy_s[0]; n++) begin
            @(posedge clk); #1;
        end
        check("held drains to idle", 32'(busy_s[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
